// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared state encoding and default timing for the reset sequencer
// Contents:
//   seq_state_e          FSM state encoding (ASSERT, RELEASE, IDLE)
//   DEFAULT_*            default parameter values for reset_sequencer
//   idx_width()          width of a stage index, never less than one bit
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_IDLE    = 2'd2
  } seq_state_e;

  localparam int DEFAULT_NUM_STAGES  = 4;
  localparam int DEFAULT_HOLD_CYCLES = 8;
  localparam int DEFAULT_GAP_CYCLES  = 4;
  localparam int DEFAULT_CNT_W       = 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// rtl/reset_sync.sv - two-flop reset synchronizer, asynchronous assert and synchronous deassert
// Ports:
//   clk       rising-edge clock
//   reset     raw active-high reset, may change at any time
//   rst_sync  active-high reset, asserts immediately, deasserts on the second clk edge
module reset_sync (
  input  logic clk,
  input  logic reset,
  output logic rst_sync
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = 1'b0;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign rst_sync = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged release of per-bank active-low synchronous resets
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset (synchronized internally)
//   sw_rst_req     level request to rerun the reset sequence
//   sw_rst_ack     one-cycle pulse when a software-initiated sequence completes
//   stage_reset_n  per-bank active-low reset, bit k drives bank k
//   busy           high while any stage is held in reset
//   all_released   high when every stage is released
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEFAULT_NUM_STAGES,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sw_rst_req,
  output logic                  sw_rst_ack,
  output logic [NUM_STAGES-1:0] stage_reset_n,
  output logic                  busy,
  output logic                  all_released
);

  localparam int                    K_W       = idx_width(NUM_STAGES);
  localparam logic [CNT_W-1:0]      HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [K_W-1:0]        K_LAST    = K_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] STAGE0    = NUM_STAGES'(1);

  logic rst_sync;

  reset_sync u_reset_sync (
    .clk      (clk),
    .reset    (reset),
    .rst_sync (rst_sync)
  );

  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  busy_q, busy_d;
  logic                  all_q, all_d;
  logic                  ack_q, ack_d;
  logic                  sw_flag_q, sw_flag_d;
  logic                  rearm_q, rearm_d;
  logic                  complete;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    stage_d   = stage_q;
    busy_d    = busy_q;
    all_d     = all_q;
    ack_d     = 1'b0;
    sw_flag_d = sw_flag_q;
    // A request must be seen low before it can trigger again, so a level
    // held past its ack never starts a second sequence.
    rearm_d   = rearm_q & sw_rst_req;
    complete  = 1'b0;

    case (state_q)
      ST_ASSERT: begin
        if (cnt_q == HOLD_LAST) begin
          stage_d = STAGE0;
          cnt_d   = '0;
          k_d     = K_W'(1);
          if (NUM_STAGES == 1) begin
            complete = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RELEASE: begin
        if (cnt_q == GAP_LAST) begin
          stage_d = stage_q | (STAGE0 << k_q);
          cnt_d   = '0;
          k_d     = k_q + 1'b1;
          if (k_q == K_LAST) begin
            complete = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_IDLE: begin
        // Requests arriving while a sequence runs are simply dropped; only
        // IDLE looks at sw_rst_req.
        if (sw_rst_req && !rearm_q) begin
          state_d   = ST_ASSERT;
          stage_d   = '0;
          busy_d    = 1'b1;
          all_d     = 1'b0;
          cnt_d     = '0;
          k_d       = '0;
          sw_flag_d = 1'b1;
          rearm_d   = 1'b1;
        end
      end

      default: begin
        state_d   = ST_ASSERT;
        stage_d   = '0;
        busy_d    = 1'b1;
        all_d     = 1'b0;
        cnt_d     = '0;
        k_d       = '0;
        sw_flag_d = 1'b0;
      end
    endcase

    // Completion is registered on the same edge as the last stage release.
    if (complete) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      all_d     = 1'b1;
      ack_d     = sw_flag_q;
      sw_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_sync) begin
    if (rst_sync) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      k_q       <= '0;
      stage_q   <= '0;
      busy_q    <= 1'b1;
      all_q     <= 1'b0;
      ack_q     <= 1'b0;
      sw_flag_q <= 1'b0;
      rearm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      stage_q   <= stage_d;
      busy_q    <= busy_d;
      all_q     <= all_d;
      ack_q     <= ack_d;
      sw_flag_q <= sw_flag_d;
      rearm_q   <= rearm_d;
    end
  end

  assign stage_reset_n = stage_q;
  assign busy          = busy_q;
  assign all_released  = all_q;
  assign sw_rst_ack    = ack_q;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- FSMD controller that generates the active-low synchronous reset_n inputs for up to NUM_STAGES banks of synchronous-reset D flip-flops.
- After power-on reset or a software request, it holds all banks in reset for HOLD_CYCLES, then releases the banks one at a time, GAP_CYCLES apart, in index order.
- Sits between the top-level reset pin and the datapath register banks, so every bank sees a clean, clock-aligned reset_n edge.

Parameters:
- NUM_STAGES, 4, number of reset_n outputs / register banks (1..8)
- HOLD_CYCLES, 8, cycles all outputs stay asserted before stage 0 releases (>=1)
- GAP_CYCLES, 4, cycles between consecutive stage releases (>=1)
- CNT_W, 8, counter width; must hold max(HOLD_CYCLES, GAP_CYCLES)-1

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- sw_rst_req  input  1  level request to rerun the reset sequence
- sw_rst_ack  output  1  one-cycle pulse when a software-initiated sequence completes
- stage_reset_n  output  NUM_STAGES  per-bank active-low synchronous reset; bit k drives bank k
- busy  output  1  high while any stage is held in reset
- all_released  output  1  high when every stage is released

Behaviour:
- Reset handling:
  - `reset` is passed through a 2-flop synchronizer: assertion is immediate and asynchronous, deassertion takes 2 clk edges.
  - The synchronized reset (rst_sync) asynchronously resets the FSM and all outputs.
- Values while rst_sync is high:
  - stage_reset_n = all 0, busy = 1, all_released = 0, sw_rst_ack = 0
  - state = ASSERT, cnt = 0, stage index k = 0, sw_flag = 0, rearm = 0
- States: ASSERT, RELEASE, IDLE.
- ASSERT:
  - cnt increments each edge.
  - On the edge where cnt == HOLD_CYCLES-1: set stage_reset_n[0] = 1, cnt = 0, k = 1, and go to RELEASE.
  - If NUM_STAGES == 1, go straight to IDLE with completion actions instead.
- RELEASE:
  - cnt increments each edge.
  - On the edge where cnt == GAP_CYCLES-1: set stage_reset_n[k] = 1, cnt = 0, k = k+1.
  - If k was NUM_STAGES-1, go to IDLE with completion actions.
- Completion actions (all registered on the same edge as the last stage release):
  - busy = 0, all_released = 1
  - sw_rst_ack = 1 for one cycle if sw_flag is set; sw_flag then clears.
- Power-on timing, with E1 = first rising edge after `reset` deasserts:
  - Stage k releases at edge E(HOLD_CYCLES + 2 + k*GAP_CYCLES).
- IDLE, software reset:
  - Trigger condition: sw_rst_req == 1 and rearm == 0, sampled on an edge.
  - On that edge S: stage_reset_n = 0, busy = 1, all_released = 0, cnt = 0, k = 0, sw_flag = 1, rearm = 1, go to ASSERT.
  - Stage k then releases at edge S + HOLD_CYCLES + k*GAP_CYCLES.
- Rearm rules:
  - rearm clears on any edge where sw_rst_req == 0.
  - A request held high past its ack therefore does not retrigger.
- sw_rst_req while busy: ignored and not queued. The rearm rule still applies.
- `reset` asserted mid-sequence:
  - All outputs return to reset values asynchronously.
  - A pending sw ack is dropped.
  - The sequence restarts as power-on after deassertion.
- Output invariants:
  - stage_reset_n bits release in ascending order and are never individually re-asserted.
  - Re-assertion of all bits is simultaneous.
  - All outputs are registered; none are glitch-prone combinational.

Decomposition:
- Package reset_seq_pkg:
  - state encoding constants ST_ASSERT = 2'd0, ST_RELEASE = 2'd1, ST_IDLE = 2'd2
  - default HOLD_CYCLES / GAP_CYCLES values
- Sub-module reset_sync:
  - 2-flop async-assert / sync-deassert synchronizer
  - ports clk, reset, rst_sync
  - instantiated once

Test Plan:
- Power-on: reset high 0–37 ns, clk period 10 ns, defaults → stage_reset_n goes 0000→0001 at E10, 0011 at E14, 0111 at E18, 1111 at E22; busy falls and all_released rises at E22; sw_rst_ack stays 0.
- Software reset: in IDLE, sw_rst_req = 1 sampled at edge S → stage_reset_n = 0000 at S; 0001 at S+8; 1111 at S+20; sw_rst_ack = 1 for exactly the cycle after S+20.
- Held request: sw_rst_req held high for 50 cycles → exactly one sequence and one ack; drop the request for 1 cycle, raise again → second sequence starts.
- Request while busy: pulse sw_rst_req at S+5 during a sequence → timing unchanged, no second sequence, one ack only.
- Reset mid-sequence: assert reset when stage_reset_n = 0011 → outputs 0000, busy = 1 immediately (async); after deassert, release schedule restarts at E10, no ack.
- Parameter sweep: NUM_STAGES = 1, HOLD_CYCLES = 1, GAP_CYCLES = 1 → stage_reset_n[0] releases at E3; all_released at E3; sw request at S releases at S+1.
